ir_xmt: RTL and testbench

NEC-protocol IR transmitter. It is the send-side counterpart of ir_rcv and runs on clk27. It accepts a 16-bit code through a valid/ready handshake, serialises a full NEC frame, and emits repeat codes while hold is asserted. It is used for test loopback into ir_rcv and for driving an external IR LED from the CPU.

---
 rtl/ir_nec_pkg.sv | 30 +++
 rtl/ir_carrier_gen.sv | 27 ++
 rtl/ir_xmt.sv | 142 ++++++++++++++
 tb/tb_ir_xmt.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared NEC protocol definitions for the IR transmitter.
// States, unit durations and the mark decode used by ir_xmt.
package ir_nec_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEADER,
      S_LSPACE,
      S_BIT_MARK,
      S_BIT_SPACE,
      S_STOP_MARK,
      S_GAP,
      S_REP_LEADER,
      S_REP_SPACE,
      S_REP_MARK
   } state_t;

   localparam int LEADER_U    = 16;
   localparam int LSPACE_U    = 8;
   localparam int RSPACE_U    = 4;
   localparam int BIT_U       = 1;
   localparam int ONE_SPACE_U = 3;
   localparam int NBITS       = 32;

   function automatic logic is_mark(input state_t s);
      return s inside {S_LEADER, S_BIT_MARK, S_STOP_MARK,
                       S_REP_LEADER, S_REP_MARK};
   endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Free-running IR carrier, restarted at each burst so it begins high.
module ir_carrier_gen #(
   parameter int DIV = 711,
   parameter int HI  = 237
) (
   input  logic clk27,
   input  logic reset,
   input  logic restart,
   output logic carrier
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] HI_C = CW'(HI);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk27) begin
      if (reset || restart || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign carrier = cnt < HI_C;

endmodule

// File: rtl/ir_xmt.sv
// NEC IR transmitter: 16-bit code in, full frame and repeat codes out.
// Define IR_TX_CARRIER_EN to modulate ir_tx with the 38 kHz carrier.
module ir_xmt
   import ir_nec_pkg::*;
#(
   parameter int UNIT_CYCLES = 15188,
   parameter int FRAME_UNITS = 196
`ifdef IR_TX_CARRIER_EN
   ,
   parameter int CARRIER_DIV = 711,
   parameter int CARRIER_HI  = 237
`endif
) (
   input  logic        clk27,
   input  logic        reset,
   input  logic [15:0] code,
   input  logic        code_valid,
   output logic        code_ready,
   input  logic        hold,
   output logic        busy,
   output logic        ir_tx,
   output logic        ir_tx_env_n,
   output logic [7:0]  frame_cnt
);

   localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [UW-1:0] U_LAST = UW'(UNIT_CYCLES - 1);
   localparam logic [7:0] P_LAST = 8'(FRAME_UNITS - 1);
   localparam logic [4:0] B_LAST = 5'(NBITS - 1);

   state_t        state, nxt;
   logic          rdy;
   logic          env_n;
   logic [UW-1:0] unit_cnt;
   logic [7:0]    pcnt;
   logic [4:0]    ucnt;
   logic [4:0]    dur;
   logic [31:0]   sr;
   logic [4:0]    bit_cnt;
   logic          unit_tick, accept, done, gap_exit;

   assign unit_tick = unit_cnt == U_LAST;
   assign accept    = code_valid & rdy;
   assign gap_exit  = state == S_GAP && unit_tick && pcnt == P_LAST;

   always_comb begin
      nxt = state;
      dur = 5'(BIT_U);
      unique case (state)
         S_LEADER, S_REP_LEADER: dur = 5'(LEADER_U);
         S_LSPACE:               dur = 5'(LSPACE_U);
         S_REP_SPACE:            dur = 5'(RSPACE_U);
         S_BIT_SPACE:            dur = sr[0] ? 5'(ONE_SPACE_U) : 5'(BIT_U);
         default:                dur = 5'(BIT_U);
      endcase
      done = unit_tick && ucnt == dur - 5'd1;
      unique case (state)
         S_IDLE:       if (accept) nxt = S_LEADER;
         S_LEADER:     if (done) nxt = S_LSPACE;
         S_LSPACE:     if (done) nxt = S_BIT_MARK;
         S_BIT_MARK:   if (done) nxt = S_BIT_SPACE;
         S_BIT_SPACE:
            if (done) nxt = (bit_cnt == B_LAST) ? S_STOP_MARK : S_BIT_MARK;
         S_STOP_MARK:  if (done) nxt = S_GAP;
         S_GAP:
            if (gap_exit) nxt = hold ? S_REP_LEADER : S_IDLE;
         S_REP_LEADER: if (done) nxt = S_REP_SPACE;
         S_REP_SPACE:  if (done) nxt = S_REP_MARK;
         S_REP_MARK:   if (done) nxt = S_GAP;
         default:      nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk27) begin
      if (reset) begin
         state <= S_IDLE;
         rdy   <= 1'b0;
         env_n <= 1'b1;
      end else begin
         state <= nxt;
         rdy   <= nxt == S_IDLE;
         env_n <= ~is_mark(nxt);
      end
   end

   always_ff @(posedge clk27) begin
      if (reset) begin
         unit_cnt  <= '0;
         pcnt      <= '0;
         ucnt      <= '0;
         sr        <= '0;
         bit_cnt   <= '0;
         frame_cnt <= '0;
      end else begin
         if (accept || unit_tick)
            unit_cnt <= '0;
         else
            unit_cnt <= unit_cnt + 1'b1;
         if (accept || (gap_exit && hold))
            pcnt <= '0;
         else if (unit_tick)
            pcnt <= pcnt + 8'd1;
         if (nxt != state)
            ucnt <= '0;
         else if (unit_tick)
            ucnt <= ucnt + 5'd1;
         // NEC order on air: addr, ~addr, cmd, ~cmd, each LSB first
         if (accept) begin
            sr      <= {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
            bit_cnt <= '0;
         end else if (state == S_BIT_SPACE && done) begin
            sr      <= sr >> 1;
            bit_cnt <= bit_cnt + 5'd1;
         end
         if (state == S_STOP_MARK && done)
            frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign code_ready  = rdy;
   assign busy        = state != S_IDLE;
   assign ir_tx_env_n = env_n;

`ifdef IR_TX_CARRIER_EN
   logic carrier;

   ir_carrier_gen #(
      .DIV(CARRIER_DIV),
      .HI (CARRIER_HI)
   ) u_carrier (
      .clk27  (clk27),
      .reset  (reset),
      .restart(is_mark(nxt) && env_n),
      .carrier(carrier)
   );

   assign ir_tx = ~env_n & carrier;
`else
   assign ir_tx = ~env_n;
`endif

endmodule

// File: tb/tb_ir_xmt.sv
// Self-checking bench for ir_xmt against a waveform-level NEC model.
module tb_ir_xmt;

   localparam int U   = 4;
   localparam int F   = 196;
   localparam int FL  = F * U;
   localparam int CD  = 9;
   localparam int CH  = 3;

   logic        clk27 = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] code = '0;
   logic        code_valid = 1'b0;
   logic        hold = 1'b0;
   logic        code_ready, busy, ir_tx, ir_tx_env_n;
   logic [7:0]  frame_cnt;

   int checks = 0;
   int errors = 0;
   logic [7:0] fc_exp = 8'd0;

   bit obs_env[$], obs_tx[$], obs_rdy[$], obs_busy[$];
   bit exp_env[$], exp_tx[$];

   ir_xmt #(
      .UNIT_CYCLES(U),
      .FRAME_UNITS(F)
`ifdef IR_TX_CARRIER_EN
      ,
      .CARRIER_DIV(CD),
      .CARRIER_HI (CH)
`endif
   ) dut (
      .clk27      (clk27),
      .reset      (reset),
      .code       (code),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .hold       (hold),
      .busy       (busy),
      .ir_tx      (ir_tx),
      .ir_tx_env_n(ir_tx_env_n),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk27 = ~clk27;

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic void push_run(input bit mark, input int len);
      for (int m = 0; m < len; m++) begin
         exp_env.push_back(!mark);
`ifdef IR_TX_CARRIER_EN
         exp_tx.push_back(mark && (m % CD) < CH);
`else
         exp_tx.push_back(mark);
`endif
      end
   endfunction

   function automatic void model_period(input logic [15:0] c, input bit rep);
      logic [31:0] p;
      p = {~c[7:0], c[7:0], ~c[15:8], c[15:8]};
      exp_env.delete();
      exp_tx.delete();
      if (!rep) begin
         push_run(1, 16 * U);
         push_run(0, 8 * U);
         for (int i = 0; i < 32; i++) begin
            push_run(1, U);
            push_run(0, p[i] ? 3 * U : U);
         end
         push_run(1, U);
      end else begin
         push_run(1, 16 * U);
         push_run(0, 4 * U);
         push_run(1, U);
      end
      while (exp_env.size() < FL) push_run(0, 1);
   endfunction

   function automatic int diff_env();
      for (int i = 0; i < obs_env.size(); i++)
         if (obs_env[i] != exp_env[i]) return i;
      return -1;
   endfunction

   function automatic int diff_tx();
      for (int i = 0; i < obs_tx.size(); i++)
         if (obs_tx[i] != exp_tx[i]) return i;
      return -1;
   endfunction

   function automatic int bad_hs();
      for (int i = 0; i < obs_rdy.size(); i++)
         if (obs_rdy[i] || !obs_busy[i]) return i;
      return -1;
   endfunction

   function automatic logic [31:0] decode_bits();
      logic [31:0] w;
      int i, len;
      w = '0;
      i = 96;
      for (int b = 0; b < 32; b++) begin
         while (i < obs_env.size() && !obs_env[i]) i++;
         len = 0;
         while (i < obs_env.size() && obs_env[i]) begin
            len++;
            i++;
         end
         w[b] = len > 2 * U;
      end
      return w;
   endfunction

   task automatic clear_obs();
      obs_env.delete();
      obs_tx.delete();
      obs_rdy.delete();
      obs_busy.delete();
   endtask

   task automatic capture(input int n, input bit junk, input int drop_at);
      for (int i = 0; i < n; i++) begin
         obs_env.push_back(ir_tx_env_n);
         obs_tx.push_back(ir_tx);
         obs_rdy.push_back(code_ready);
         obs_busy.push_back(busy);
         if (junk) begin
            code_valid = i < n - 1;
            code = 16'hFFFF;
         end
         if (i == drop_at) hold = 1'b0;
         @(negedge clk27);
      end
   endtask

   task automatic send(input logic [15:0] c, output bit ok);
      int t = 0;
      while (!code_ready && t < 3 * FL) begin
         @(negedge clk27);
         t++;
      end
      ok = code_ready;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=no_ready required=ready");
         return;
      end
      code = c;
      code_valid = 1'b1;
      @(negedge clk27);
      code_valid = 1'b0;
      code = 16'($urandom);
   endtask

   task automatic check_period(input string nm, input logic [15:0] c,
                               input bit rep);
      int d;
      model_period(c, rep);
      d = diff_env();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL %s_env code=%h idx=%0d actual=%b required=%b",
                  nm, c, d, obs_env[d], exp_env[d]);
      end
      d = diff_tx();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL %s_tx code=%h idx=%0d actual=%b required=%b",
                  nm, c, d, obs_tx[d], exp_tx[d]);
      end
      d = bad_hs();
      checks++;
      if (d !== -1) begin
         errors++;
         $display("FAIL %s_handshake idx=%0d actual=rdy%b/busy%b required=rdy0/busy1",
                  nm, d, obs_rdy[d], obs_busy[d]);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk27);
      checks++;
      if ({code_ready, busy, ir_tx, ir_tx_env_n, frame_cnt} !== {4'b0001, 8'd0}) begin
         errors++;
         $display("FAIL reset_levels actual=%b_%h required=0001_00",
                  {code_ready, busy, ir_tx, ir_tx_env_n}, frame_cnt);
      end
      reset = 1'b0;
      @(negedge clk27);
      checks++;
      if (code_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready actual=%b required=1", code_ready);
      end
   endtask

   task automatic test_frame(input logic [15:0] c);
      bit ok;
      logic [31:0] w;
      repeat ($urandom_range(0, 5)) @(negedge clk27);
      send(c, ok);
      if (!ok) return;
      clear_obs();
      capture(FL, 0, -1);
      check_period("frame", c, 0);
      w = decode_bits();
      checks++;
      if (w !== {~c[7:0], c[7:0], ~c[15:8], c[15:8]}) begin
         errors++;
         $display("FAIL frame_decode actual=%h required=%h",
                  w, {~c[7:0], c[7:0], ~c[15:8], c[15:8]});
      end
      fc_exp++;
      checks++;
      if (code_ready !== 1'b1 || frame_cnt !== fc_exp) begin
         errors++;
         $display("FAIL frame_end actual=rdy%b/cnt%0d required=rdy1/cnt%0d",
                  code_ready, frame_cnt, fc_exp);
      end
   endtask

   task automatic test_busy_ignore();
      bit ok;
      logic [15:0] c;
      c = 16'($urandom);
      send(c, ok);
      if (!ok) return;
      clear_obs();
      capture(FL, 1, -1);
      check_period("busy", c, 0);
      fc_exp++;
      checks++;
      if (code_ready !== 1'b1 || frame_cnt !== fc_exp) begin
         errors++;
         $display("FAIL busy_end actual=rdy%b/cnt%0d required=rdy1/cnt%0d",
                  code_ready, frame_cnt, fc_exp);
      end
   endtask

   task automatic test_repeat();
      bit ok;
      logic [15:0] c;
      c = 16'($urandom);
      hold = 1'b1;
      send(c, ok);
      if (!ok) return;
      clear_obs();
      capture(FL, 0, -1);
      check_period("rep_frame", c, 0);
      fc_exp++;
      for (int r = 0; r < 3; r++) begin
         clear_obs();
         capture(FL, 0, (r == 2) ? int'($urandom_range(0, FL - 2)) : -1);
         check_period($sformatf("repeat%0d", r), c, 1);
      end
      checks++;
      if (code_ready !== 1'b1 || frame_cnt !== fc_exp) begin
         errors++;
         $display("FAIL repeat_end actual=rdy%b/cnt%0d required=rdy1/cnt%0d",
                  code_ready, frame_cnt, fc_exp);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [15:0] c;
      logic [31:0] p;
      int pos, k;
      c = 16'($urandom);
      p = {~c[7:0], c[7:0], ~c[15:8], c[15:8]};
      k = $urandom_range(0, 31);
      pos = 24 * U;
      for (int j = 0; j < k; j++) pos += U + (p[j] ? 3 * U : U);
      pos += U;
      send(c, ok);
      if (!ok) return;
      clear_obs();
      capture(pos + 1, 0, -1);
      reset = 1'b1;
      @(negedge clk27);
      fc_exp = 8'd0;
      checks++;
      if ({code_ready, busy, ir_tx, ir_tx_env_n, frame_cnt} !== {4'b0001, 8'd0}) begin
         errors++;
         $display("FAIL midreset_levels bit=%0d actual=%b_%h required=0001_00",
                  k, {code_ready, busy, ir_tx, ir_tx_env_n}, frame_cnt);
      end
      reset = 1'b0;
      @(negedge clk27);
      checks++;
      if (code_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ready actual=%b required=1", code_ready);
      end
      test_frame(16'($urandom));
   endtask

   initial begin
      test_reset();
      test_frame(16'h1A2B);
      test_frame(16'h00FF);
      for (int i = 0; i < 2; i++) test_frame(16'($urandom));
      test_busy_ignore();
      test_repeat();
      test_reset_mid();
      test_frame(16'h0000);
      test_frame(16'hFFFF);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
